// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the byte-serial instruction fetch unit:
// FSM encoding, opcode length classes and the length-decode function.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        FETCH_OP = 2'd0,
        FETCH_LO = 2'd1,
        FETCH_HI = 2'd2,
        HOLD     = 2'd3
    } state_t;

    localparam logic [1:0] CLASS_ONE_A = 2'b00;
    localparam logic [1:0] CLASS_TWO   = 2'b01;
    localparam logic [1:0] CLASS_THREE = 2'b10;
    localparam logic [1:0] CLASS_ONE_B = 2'b11;

    localparam logic [1:0] LEN_1 = 2'd1;
    localparam logic [1:0] LEN_2 = 2'd2;
    localparam logic [1:0] LEN_3 = 2'd3;

    function automatic logic [1:0] decode_len(input logic [7:0] op);
        logic [1:0] len;
        unique case (op[7:6])
            CLASS_TWO:   len = LEN_2;
            CLASS_THREE: len = LEN_3;
            CLASS_ONE_A: len = LEN_1;
            CLASS_ONE_B: len = LEN_1;
            default:     len = LEN_1;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/fetch_unit_decode.sv
// Opcode byte to instruction length (1..3 bytes), used on the
// memory read data during the opcode fetch cycle.
module instr_length_decode
    import fetch_unit_pkg::*;
(
    input  logic [7:0] opcode,
    output logic [1:0] len
);

    assign len = decode_len(opcode);

endmodule

// File: rtl/fetch_unit.sv
// Byte-serial fetch: reads opcode then up to two operand bytes,
// then holds the assembled instruction until decode accepts it.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [15:0] RESET_VECTOR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] memAddr,
    output logic        memOutputEnable,
    output logic        memWriteEnable,
    input  logic [7:0]  memData,
    input  logic        jumpValid,
    input  logic [15:0] jumpAddr,
    output logic        instrValid,
    input  logic        instrReady,
    output logic [7:0]  opcode,
    output logic [15:0] operand,
    output logic [1:0]  instrLen,
    output logic [15:0] instrPc,
    output logic [15:0] pc
);

    state_t     state;
    state_t     next_state;
    logic [1:0] dec_len;

    instr_length_decode u_len (
        .opcode (memData),
        .len    (dec_len)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH_OP;
        end else begin
            state <= next_state;
        end
    end

    // A redirect overrides every state and drops any partial fetch.
    always_comb begin
        next_state = state;
        if (jumpValid) begin
            next_state = FETCH_OP;
        end else begin
            unique case (state)
                FETCH_OP: next_state = (dec_len == LEN_1) ? HOLD : FETCH_LO;
                FETCH_LO: next_state = (instrLen == LEN_2) ? HOLD : FETCH_HI;
                FETCH_HI: next_state = HOLD;
                HOLD:     next_state = instrReady ? FETCH_OP : HOLD;
                default:  next_state = FETCH_OP;
            endcase
        end
    end

    // Memory enable is gated by rst so it drops without waiting for a clock.
    always_comb begin
        instrValid      = (state == HOLD);
        memOutputEnable = !rst && (state != HOLD);
        memWriteEnable  = 1'b0;
        memAddr         = pc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_VECTOR;
            opcode   <= 8'h00;
            operand  <= 16'h0000;
            instrLen <= LEN_1;
            instrPc  <= RESET_VECTOR;
        end else if (jumpValid) begin
            pc <= jumpAddr;
        end else begin
            unique case (state)
                FETCH_OP: begin
                    opcode   <= memData;
                    instrLen <= dec_len;
                    instrPc  <= pc;
                    operand  <= 16'h0000;
                    pc       <= pc + 16'd1;
                end
                FETCH_LO: begin
                    operand[7:0] <= memData;
                    pc           <= pc + 16'd1;
                end
                FETCH_HI: begin
                    operand[15:8] <= memData;
                    pc            <= pc + 16'd1;
                end
                HOLD: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios, then random ready/jump
// traffic scored against a timeline model of the instruction stream.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] memAddr;
    logic        memOutputEnable;
    logic        memWriteEnable;
    logic [7:0]  memData;
    logic        jumpValid = 1'b0;
    logic [15:0] jumpAddr = 16'h0000;
    logic        instrValid;
    logic        instrReady = 1'b1;
    logic [7:0]  opcode;
    logic [15:0] operand;
    logic [1:0]  instrLen;
    logic [15:0] instrPc;
    logic [15:0] pc;

    logic [7:0] mem [0:65535];

    always #5 clk = ~clk;

    assign memData = mem[memAddr];

    fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .memAddr         (memAddr),
        .memOutputEnable (memOutputEnable),
        .memWriteEnable  (memWriteEnable),
        .memData         (memData),
        .jumpValid       (jumpValid),
        .jumpAddr        (jumpAddr),
        .instrValid      (instrValid),
        .instrReady      (instrReady),
        .opcode          (opcode),
        .operand         (operand),
        .instrLen        (instrLen),
        .instrPc         (instrPc),
        .pc              (pc)
    );

    typedef struct {
        logic [7:0]  op;
        logic [15:0] opnd;
        logic [1:0]  len;
        logic [15:0] ipc;
        logic [15:0] npc;
    } exp_t;

    exp_t iq[$];
    bit   vq[$];
    bit   sb_on = 1'b0;
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic int mlen(input logic [7:0] b);
        case (b[7:6])
            2'b01:   return 2;
            2'b10:   return 3;
            default: return 1;
        endcase
    endfunction

    task automatic chk_instr(input string tag, input logic [7:0] op,
                             input logic [15:0] opnd, input int len,
                             input logic [15:0] ipc, input logic [15:0] npc);
        chk({tag, "_valid"}, instrValid, 1);
        chk({tag, "_opcode"}, opcode, op);
        chk({tag, "_operand"}, operand, opnd);
        chk({tag, "_len"}, instrLen, len);
        chk({tag, "_ipc"}, instrPc, ipc);
        chk({tag, "_pc"}, pc, npc);
    endtask

    // Monitor: scores per-cycle valid/enable and every accepted instruction.
    initial begin
        exp_t e;
        bit   v;
        forever begin
            @(negedge clk);
            if (sb_on) begin
                if (vq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL valid_q: no expected entry");
                end else begin
                    v = vq.pop_front();
                    chk("rnd_valid", instrValid, v);
                    chk("rnd_oe", memOutputEnable, !v);
                end
                if (instrValid && instrReady) begin
                    if (iq.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL instr_q: unexpected handshake pc %h", instrPc);
                    end else begin
                        e = iq.pop_front();
                        chk("rnd_opcode", opcode, e.op);
                        chk("rnd_operand", operand, e.opnd);
                        chk("rnd_len", instrLen, e.len);
                        chk("rnd_ipc", instrPc, e.ipc);
                        chk("rnd_pc", pc, e.npc);
                    end
                end
            end
        end
    end

    initial begin
        int          st;
        int          ln;
        logic [15:0] a;
        logic [15:0] ja;
        bit          r;
        bit          j;
        bit          v;
        exp_t        e;

        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0000] = 8'h05;
        mem[16'h0001] = 8'h4A;
        mem[16'h0002] = 8'h12;
        mem[16'h0003] = 8'h8C;
        mem[16'h0004] = 8'h34;
        mem[16'h0005] = 8'h12;
        mem[16'h0006] = 8'h55;
        mem[16'h00FF] = 8'h07;

        repeat (2) @(posedge clk);
        #2;
        chk("rst_valid", instrValid, 0);
        chk("rst_oe", memOutputEnable, 0);
        chk("rst_we", memWriteEnable, 0);
        chk("rst_addr", memAddr, 16'h0000);
        chk("rst_pc", pc, 16'h0000);
        chk("rst_opcode", opcode, 0);
        chk("rst_operand", operand, 0);
        chk("rst_len", instrLen, 1);
        chk("rst_ipc", instrPc, 16'h0000);

        rst = 1'b0;
        #1;
        chk("op0_oe", memOutputEnable, 1);
        chk("op0_addr", memAddr, 16'h0000);
        tick();
        chk_instr("i05", 8'h05, 16'h0000, 1, 16'h0000, 16'h0001);

        tick();
        chk("i4a_fetch_valid", instrValid, 0);
        chk("i4a_fetch_addr", memAddr, 16'h0001);
        tick();
        tick();
        chk_instr("i4a", 8'h4A, 16'h0012, 2, 16'h0001, 16'h0003);

        tick();
        tick();
        tick();
        tick();
        chk_instr("i8c", 8'h8C, 16'h1234, 3, 16'h0003, 16'h0006);
        instrReady = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_instr("stall", 8'h8C, 16'h1234, 3, 16'h0003, 16'h0006);
            chk("stall_oe", memOutputEnable, 0);
            chk("stall_addr", memAddr, 16'h0006);
        end
        instrReady = 1'b1;
        tick();
        chk("resume_valid", instrValid, 0);
        chk("resume_oe", memOutputEnable, 1);
        chk("resume_addr", memAddr, 16'h0006);

        tick();
        chk("lo_addr", memAddr, 16'h0007);
        jumpValid = 1'b1;
        jumpAddr  = 16'h00FF;
        tick();
        jumpValid = 1'b0;
        chk("jmp_pc", pc, 16'h00FF);
        chk("jmp_valid", instrValid, 0);
        tick();
        chk_instr("i07", 8'h07, 16'h0000, 1, 16'h00FF, 16'h0100);

        mem[16'h0000] = 8'hAA;
        mem[16'h0001] = 8'hBB;
        mem[16'hFFFF] = 8'h80;
        jumpValid = 1'b1;
        jumpAddr  = 16'hFFFF;
        tick();
        jumpValid = 1'b0;
        chk("wrap_pc0", pc, 16'hFFFF);
        chk("wrap_valid", instrValid, 0);
        tick();
        chk("wrap_pc1", pc, 16'h0000);
        tick();
        tick();
        chk_instr("i80", 8'h80, 16'hBBAA, 3, 16'hFFFF, 16'h0002);

        jumpValid = 1'b1;
        jumpAddr  = 16'h0003;
        tick();
        jumpValid = 1'b0;
        tick();
        tick();
        chk("hi_oe", memOutputEnable, 1);
        chk("hi_addr", memAddr, 16'h0005);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_valid", instrValid, 0);
        chk("arst_oe", memOutputEnable, 0);
        chk("arst_addr", memAddr, 16'h0000);
        chk("arst_pc", pc, 16'h0000);
        tick();
        rst = 1'b0;
        #1;
        chk("rel_oe", memOutputEnable, 1);
        chk("rel_addr", memAddr, 16'h0000);
        tick();
        tick();
        tick();
        chk_instr("iaa", 8'hAA, 16'h12BB, 3, 16'h0000, 16'h0003);

        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        rst        = 1'b1;
        jumpValid  = 1'b0;
        instrReady = 1'b0;
        tick();
        tick();
        rst   = 1'b0;
        sb_on = 1'b1;
        st    = 0;
        a     = 16'h0000;
        ln    = mlen(mem[a]);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc > 0) tick();
            r  = ($urandom_range(0, 9) < 7);
            j  = ($urandom_range(0, 11) == 0);
            ja = ($urandom_range(0, 3) == 0) ?
                 16'hFFFF - 16'($urandom_range(0, 2)) : 16'($urandom);
            instrReady = r;
            jumpValid  = j;
            jumpAddr   = ja;
            v = (cyc >= st + ln);
            vq.push_back(v);
            if (v && r) begin
                e.op   = mem[a];
                e.opnd = 16'h0000;
                if (ln >= 2) e.opnd[7:0] = mem[a + 16'd1];
                if (ln == 3) e.opnd[15:8] = mem[a + 16'd2];
                e.len  = 2'(ln);
                e.ipc  = a;
                e.npc  = a + 16'(ln);
                iq.push_back(e);
            end
            if (j) begin
                st = cyc + 1;
                a  = ja;
                ln = mlen(mem[a]);
            end else if (v && r) begin
                st = cyc + 1;
                a  = a + 16'(ln);
                ln = mlen(mem[a]);
            end
        end
        tick();
        sb_on     = 1'b0;
        jumpValid = 1'b0;
        chk("instr_q_left", iq.size(), 0);
        chk("valid_q_left", vq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
